// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. Shows a 32-bit hex value with per-digit decimal
// points and blanking. A load is held in pending registers and only moves
// into the displayed (shadow) copy at a frame boundary, so a scan is never torn.
module seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        update_pending,
  output logic        frame_done
);

  logic [CNT_W-1:0] div_cnt_reg;
  logic [2:0]       idx_reg;
  logic             tick;
  logic             frame_tick;

  logic [31:0] shadow_data_reg;
  logic [7:0]  shadow_dp_reg;
  logic [7:0]  shadow_blank_reg;
  logic [31:0] pending_data_reg;
  logic [7:0]  pending_dp_reg;
  logic [7:0]  pending_blank_reg;
  logic        update_pending_reg;
  logic        frame_done_reg;

  logic [3:0]  nib [8];
  logic [7:0]  an_mask;
  logic [7:0]  an_next;
  logic [7:0]  seg_next;
  logic [7:0]  an_reg;
  logic [7:0]  seg_reg;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      4'hA:    decode = 7'h08;
      4'hB:    decode = 7'h03;
      4'hC:    decode = 7'h46;
      4'hD:    decode = 7'h21;
      4'hE:    decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign tick       = (div_cnt_reg == CNT_W'(CLK_DIV - 1));
  assign frame_tick = tick && (idx_reg == 3'd7);

  // Per-digit views: nibble of the shown value and the one-hot-low anode mask.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign nib[gi]     = shadow_data_reg[4*gi +: 4];
    assign an_mask[gi] = (idx_reg != 3'(gi));
  end

  // Slot divider: counts 0..CLK_DIV-1, one digit slot per wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Digit index advances once per slot and wraps 7 -> 0 at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (tick) begin
      idx_reg <= idx_reg + 3'd1;
    end
  end

  // Load handshake: capture into pending, promote to shadow only at a frame
  // boundary; a load coinciding with the boundary bypasses pending entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_reg    <= '0;
      shadow_dp_reg      <= '0;
      shadow_blank_reg   <= '0;
      pending_data_reg   <= '0;
      pending_dp_reg     <= '0;
      pending_blank_reg  <= '0;
      update_pending_reg <= 1'b0;
    end else if (frame_tick) begin
      update_pending_reg <= 1'b0;
      if (load) begin
        shadow_data_reg  <= data_in;
        shadow_dp_reg    <= dp_in;
        shadow_blank_reg <= blank_in;
      end else if (update_pending_reg) begin
        shadow_data_reg  <= pending_data_reg;
        shadow_dp_reg    <= pending_dp_reg;
        shadow_blank_reg <= pending_blank_reg;
      end
    end else if (load) begin
      pending_data_reg   <= data_in;
      pending_dp_reg     <= dp_in;
      pending_blank_reg  <= blank_in;
      update_pending_reg <= 1'b1;
    end
  end

  // One-cycle pulse in the cycle after the 7 -> 0 wrap tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_tick;
    end
  end

  // Pin values for the current slot; a blanked digit keeps anode and segments dark.
  always_comb begin
    an_next  = an_mask;
    seg_next = {~shadow_dp_reg[idx_reg], decode(nib[idx_reg])};
    if (shadow_blank_reg[idx_reg]) begin
      an_next  = 8'hFF;
      seg_next = 8'hFF;
    end
  end

  // Registered pins, dark during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg  <= 8'hFF;
      seg_reg <= 8'hFF;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign AN             = an_reg;
  assign SEG            = seg_reg;
  assign update_pending = update_pending_reg;
  assign frame_done     = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with CLK_DIV=4.
// Expected responses are queued with the cycle (posedges since reset release)
// at which they must appear; a negedge monitor pops and compares them.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        update_pending;
  logic        frame_done;

  seg_scan_driver #(.CLK_DIV(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .data_in        (data_in),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .SEG            (SEG),
    .AN             (AN),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  typedef struct {
    int         cyc;
    int         kind;   // 0 pins, 1 frame_done, 2 update_pending, 3 reset state
    logic [7:0] an;
    logic [7:0] seg;
    logic       val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   p;
  int   n_cmp;
  int   n_bad;
  int   mi;

  logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_t2  [8] = '{8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
  logic [7:0] seg_t5  [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] an_t5   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) p <= 0;
    else     p <= p + 1;
  end

  // Monitor: compare every queued expectation due at this cycle.
  always @(negedge clk) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].cyc == p) begin
        n_cmp++;
        case (sb[mi].kind)
          0: if (AN !== sb[mi].an || SEG !== sb[mi].seg) begin
               n_bad++;
               $display("FAIL %s p=%0d AN=%h SEG=%h required AN=%h SEG=%h",
                        sb[mi].name, p, AN, SEG, sb[mi].an, sb[mi].seg);
             end
          1: if (frame_done !== sb[mi].val) begin
               n_bad++;
               $display("FAIL %s p=%0d frame_done=%b required %b",
                        sb[mi].name, p, frame_done, sb[mi].val);
             end
          2: if (update_pending !== sb[mi].val) begin
               n_bad++;
               $display("FAIL %s p=%0d update_pending=%b required %b",
                        sb[mi].name, p, update_pending, sb[mi].val);
             end
          default: if (AN !== 8'hFF || SEG !== 8'hFF || update_pending !== 1'b0 || frame_done !== 1'b0) begin
               n_bad++;
               $display("FAIL %s AN=%h SEG=%h upd=%b fd=%b required FF FF 0 0",
                        sb[mi].name, AN, SEG, update_pending, frame_done);
             end
        endcase
        sb.delete(mi);
      end else if (sb[mi].cyc < p) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed at p=%0d (now p=%0d)", sb[mi].name, sb[mi].cyc, p);
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic push_pins(input int c, input logic [7:0] an, input logic [7:0] seg, input string nm);
    exp_t e;
    e = '{c, 0, an, seg, 1'b0, nm};
    sb.push_back(e);
  endtask

  task automatic push_bit(input int c, input int kind, input logic v, input string nm);
    exp_t e;
    e = '{c, kind, 8'h00, 8'h00, v, nm};
    sb.push_back(e);
  endtask

  task automatic wait_p(input int n);
    while (p < n) @(negedge clk);
  endtask

  // Drive load so it is sampled by posedge number 'at'.
  task automatic do_load(input int at, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    wait_p(at - 1);
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    load     = 1'b1;
    $display("load p=%0d data=%h dp=%h blank=%h", at, d, dp, bl);
    @(negedge clk);
    load     = 1'b0;
    data_in  = 32'hFFFFFFFF;
    dp_in    = 8'h00;
    blank_in = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout p=%0d", p);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    blank_in = '0;
    n_cmp    = 0;
    n_bad    = 0;

    // Reset state, then plain scan of zeros with frame_done once per 32 cycles.
    push_bit(0, 3, 1'b0, "reset_state");
    for (int q = 1; q <= 33; q++) push_pins(q, an_tab[((q - 1) / 4) % 8], 8'hC0, "scan_zero");
    push_bit(31, 1, 1'b0, "fd_before");
    push_bit(32, 1, 1'b1, "fd_pulse");
    push_bit(33, 1, 1'b0, "fd_after");
    push_bit(64, 1, 1'b1, "fd_pulse2");
    repeat (3) @(negedge clk);
    $display("reset released");
    rst = 1'b0;

    // Mid-frame load with DP on digit 0, shown from the next frame.
    wait_p(36);
    push_bit(39, 2, 1'b0, "upd_idle");
    push_bit(40, 2, 1'b1, "upd_set");
    push_bit(63, 2, 1'b1, "upd_hold");
    push_bit(64, 2, 1'b0, "upd_clear");
    push_pins(64, 8'h7F, 8'hC0, "old_frame_tail");
    for (int k = 0; k < 8; k++) begin
      push_pins(65 + 4 * k, an_tab[k], seg_t2[k], "hex_frame");
      push_pins(68 + 4 * k, an_tab[k], seg_t2[k], "hex_frame_end");
    end
    do_load(40, 32'h89ABCDEF, 8'h01, 8'h00);

    // Two loads in one frame: the last one wins.
    wait_p(90);
    push_bit(100, 2, 1'b1, "upd_first");
    push_bit(110, 2, 1'b1, "upd_second");
    push_bit(128, 2, 1'b0, "upd_clear2");
    for (int q = 129; q <= 160; q++) push_pins(q, an_tab[(q - 129) / 4], 8'hA4, "last_load_wins");
    do_load(100, 32'h11111111, 8'h00, 8'h00);
    do_load(110, 32'h22222222, 8'h00, 8'h00);

    // Load on the boundary tick goes straight to the display.
    wait_p(150);
    push_bit(159, 2, 1'b0, "upd_pre_boundary");
    push_bit(160, 2, 1'b0, "upd_on_boundary");
    push_bit(160, 1, 1'b1, "fd_boundary");
    push_bit(161, 2, 1'b0, "upd_post_boundary");
    push_pins(161, 8'hFE, 8'hF8, "boundary_d0");
    push_pins(164, 8'hFE, 8'hF8, "boundary_d0_end");
    push_pins(165, 8'hFD, 8'hC0, "boundary_d1");
    push_pins(189, 8'h7F, 8'hC0, "boundary_d7");
    do_load(160, 32'h00000007, 8'h00, 8'h00);

    // Upper four digits blanked.
    wait_p(165);
    push_bit(170, 2, 1'b1, "upd_blank");
    push_bit(192, 2, 1'b0, "upd_blank_clear");
    for (int k = 0; k < 8; k++) begin
      push_pins(193 + 4 * k, an_t5[k], seg_t5[k], "blank_frame");
      push_pins(196 + 4 * k, an_t5[k], seg_t5[k], "blank_frame_end");
    end
    do_load(170, 32'h12345678, 8'h00, 8'hF0);

    // Reset while an update is pending discards it.
    wait_p(225);
    push_bit(229, 2, 1'b0, "upd_pre_abort");
    push_bit(230, 2, 1'b1, "upd_abort_set");
    push_bit(235, 2, 1'b1, "upd_abort_hold");
    do_load(230, 32'hAAAAAAAA, 8'hFF, 8'h00);
    wait_p(240);
    rst = 1'b1;
    $display("reset asserted with update pending");
    @(negedge clk);
    push_bit(0, 3, 1'b0, "reset_midscan");
    push_bit(1, 2, 1'b0, "upd_after_reset");
    push_bit(32, 1, 1'b1, "fd_after_reset");
    push_bit(33, 2, 1'b0, "upd_discarded");
    for (int k = 0; k < 8; k++) begin
      push_pins(1 + 4 * k, an_tab[k], 8'hC0, "zero_after_reset");
      push_pins(33 + 4 * k, an_tab[k], 8'hC0, "pending_discarded");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("reset released");

    wait_p(70);
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    while (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never checked (due p=%0d)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
